// File: rtl/muldiv_unit_if.sv
// Start/complete handshake between the control unit (master) and the
// iterative multiply/divide responder (slave).
interface muldiv_unit_if;
    logic        en;
    logic [1:0]  op;
    logic [31:0] srcA;
    logic [31:0] srcB;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        busy;
    logic        done;
    logic        div_by_zero;

    modport master (
        output en, op, srcA, srcB,
        input  hi, lo, busy, done, div_by_zero
    );

    modport slave (
        input  en, op, srcA, srcB,
        output hi, lo, busy, done, div_by_zero
    );
endinterface

// File: rtl/muldiv_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit backing the MIPS HI/LO registers.
// Works on operand magnitudes for 32 cycles, then applies signs in a single fix-up cycle.
module muldiv_unit (
    input  logic          clk,
    input  logic          rst,
    muldiv_unit_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

    state_t      state_q, state_d;
    logic [5:0]  cnt_q, cnt_d;
    logic [31:0] a_q, a_d;
    logic [31:0] b_q, b_d;
    logic [63:0] acc_q, acc_d;
    logic [31:0] rem_q, rem_d;
    logic        div_q, div_d;
    logic        dz_q, dz_d;
    logic        negq_q, negq_d;
    logic        negr_q, negr_d;
    logic [31:0] hi_q, hi_d;
    logic [31:0] lo_q, lo_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        dbz_q, dbz_d;

    logic        sgn;
    logic [31:0] mag_a, mag_b;
    logic [32:0] sum, rem_sh, diff;

    function automatic logic [31:0] mag32(input logic signed [31:0] v);
        return v[31] ? 32'(-v) : v;
    endfunction

    function automatic logic [31:0] cneg32(input logic [31:0] v, input logic n);
        return n ? (~v + 32'd1) : v;
    endfunction

    function automatic logic [63:0] cneg64(input logic [63:0] v, input logic n);
        return n ? (~v + 64'd1) : v;
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            acc_q   <= '0;
            rem_q   <= '0;
            div_q   <= 1'b0;
            dz_q    <= 1'b0;
            negq_q  <= 1'b0;
            negr_q  <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            dbz_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            b_q     <= b_d;
            acc_q   <= acc_d;
            rem_q   <= rem_d;
            div_q   <= div_d;
            dz_q    <= dz_d;
            negq_q  <= negq_d;
            negr_q  <= negr_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            dbz_q   <= dbz_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        a_d     = a_q;
        b_d     = b_q;
        acc_d   = acc_q;
        rem_d   = rem_q;
        div_d   = div_q;
        dz_d    = dz_q;
        negq_d  = negq_q;
        negr_d  = negr_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        dbz_d   = 1'b0;
        sgn     = ~bus.op[0];
        mag_a   = sgn ? mag32(bus.srcA) : bus.srcA;
        mag_b   = sgn ? mag32(bus.srcB) : bus.srcB;
        sum     = '0;
        rem_sh  = '0;
        diff    = '0;

        case (state_q)
            IDLE: begin
                if (bus.en) begin
                    div_d  = bus.op[1];
                    negq_d = sgn & (bus.srcA[31] ^ bus.srcB[31]);
                    negr_d = sgn & bus.op[1] & bus.srcA[31];
                    b_d    = mag_b;
                    // Multiply keeps the multiplier in acc[31:0]; divide keeps the dividend there.
                    acc_d  = {32'd0, bus.op[1] ? mag_a : mag_b};
                    rem_d  = '0;
                    cnt_d  = '0;
                    busy_d = 1'b1;
                    dz_d   = bus.op[1] && (bus.srcB == 32'd0);
                    // A zero divisor reports the dividend exactly as presented.
                    a_d     = dz_d ? bus.srcA : mag_a;
                    state_d = dz_d ? FIX : RUN;
                end
            end
            RUN: begin
                cnt_d = cnt_q + 6'd1;
                if (div_q) begin
                    rem_sh = {rem_q, acc_q[31]};
                    diff   = rem_sh - {1'b0, b_q};
                    rem_d  = diff[32] ? rem_sh[31:0] : diff[31:0];
                    acc_d  = {acc_q[63:32], acc_q[30:0], ~diff[32]};
                end else begin
                    sum   = {1'b0, acc_q[63:32]} + (acc_q[0] ? {1'b0, a_q} : 33'd0);
                    acc_d = {sum, acc_q[31:1]};
                end
                if (cnt_q == 6'd31) state_d = FIX;
            end
            FIX: begin
                state_d = IDLE;
                busy_d  = 1'b0;
                done_d  = 1'b1;
                if (dz_q) begin
                    hi_d  = a_q;
                    lo_d  = 32'hFFFF_FFFF;
                    dbz_d = 1'b1;
                end else if (div_q) begin
                    lo_d = cneg32(acc_q[31:0], negq_q);
                    hi_d = cneg32(rem_q, negr_q);
                end else begin
                    {hi_d, lo_d} = cneg64(acc_q, negq_q);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.hi          = hi_q;
    assign bus.lo          = lo_q;
    assign bus.busy        = busy_q;
    assign bus.done        = done_q;
    assign bus.div_by_zero = dbz_q;
endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit: vector table plus hand-written handshake,
// back-to-back and mid-operation reset sequences.
module tb_muldiv_unit;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    muldiv_unit_if bus();

    muldiv_unit dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] hi;
        logic [31:0] lo;
        logic        dz;
        int          lat;
    } vec_t;

    vec_t vecs[12];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Called at a falling edge; returns at the falling edge after the accept edge.
    task automatic start(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        bus.en   = 1'b1;
        bus.op   = o;
        bus.srcA = a;
        bus.srcB = b;
        @(posedge clk);
        @(negedge clk);
        bus.en = 1'b0;
    endtask

    // Counts cycles until done, noting busy dropping or div_by_zero rising too early.
    task automatic wait_done(output int lat, output bit ok);
        lat = 0;
        ok  = 1'b1;
        while (!bus.done && lat < 100) begin
            if (!bus.busy || bus.div_by_zero) ok = 1'b0;
            @(posedge clk);
            @(negedge clk);
            lat++;
        end
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        int lat;
        bit ok;
        logic [31:0] hold_hi;

        vecs[0]  = '{2'b00, 32'hFFFFFFFD, 32'd5,        32'hFFFFFFFF, 32'hFFFFFFF1, 1'b0, 33};
        vecs[1]  = '{2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0, 33};
        vecs[2]  = '{2'b10, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0, 33};
        vecs[3]  = '{2'b11, 32'd100,      32'd7,        32'd2,        32'd14,       1'b0, 33};
        vecs[4]  = '{2'b10, 32'h80000000, 32'hFFFFFFFF, 32'd0,        32'h80000000, 1'b0, 33};
        vecs[5]  = '{2'b11, 32'h00001234, 32'd0,        32'h00001234, 32'hFFFFFFFF, 1'b1, 1};
        vecs[6]  = '{2'b00, 32'd6,        32'd7,        32'd0,        32'd42,       1'b0, 33};
        vecs[7]  = '{2'b10, 32'd7,        32'hFFFFFFFE, 32'd1,        32'hFFFFFFFD, 1'b0, 33};
        vecs[8]  = '{2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd0,        32'd1,        1'b0, 33};
        vecs[9]  = '{2'b10, 32'hFFFFFFF0, 32'd0,        32'hFFFFFFF0, 32'hFFFFFFFF, 1'b1, 1};
        vecs[10] = '{2'b01, 32'h00010000, 32'h00010000, 32'd1,        32'd0,        1'b0, 33};
        vecs[11] = '{2'b11, 32'hFFFFFFFF, 32'd1,        32'd0,        32'hFFFFFFFF, 1'b0, 33};

        bus.en = 1'b0; bus.op = 2'b00; bus.srcA = '0; bus.srcB = '0;
        @(negedge clk);
        check("reset_hi",   {32'd0, bus.hi}, 64'd0);
        check("reset_lo",   {32'd0, bus.lo}, 64'd0);
        check("reset_ctl",  {61'd0, bus.busy, bus.done, bus.div_by_zero}, 64'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 12; i++) begin
            start(vecs[i].op, vecs[i].a, vecs[i].b);
            wait_done(lat, ok);
            check($sformatf("v%0d_latency", i), 64'(lat), 64'(vecs[i].lat));
            check($sformatf("v%0d_busy_run", i), {63'd0, ok}, 64'd1);
            check($sformatf("v%0d_hi", i), {32'd0, bus.hi}, {32'd0, vecs[i].hi});
            check($sformatf("v%0d_lo", i), {32'd0, bus.lo}, {32'd0, vecs[i].lo});
            check($sformatf("v%0d_dz", i), {63'd0, bus.div_by_zero}, {63'd0, vecs[i].dz});
            check($sformatf("v%0d_busy_done", i), {63'd0, bus.busy}, 64'd0);
            hold_hi = bus.hi;
            @(posedge clk);
            @(negedge clk);
            check($sformatf("v%0d_done_pulse", i), {62'd0, bus.done, bus.div_by_zero}, 64'd0);
            check($sformatf("v%0d_hold", i), {32'd0, bus.hi}, {32'd0, hold_hi});
        end

        // en and operand changes while busy are ignored.
        start(2'b00, 32'hFFFFFFFD, 32'd5);
        for (int k = 1; k <= 5; k++) begin
            @(posedge clk);
            @(negedge clk);
        end
        bus.en = 1'b1; bus.op = 2'b11; bus.srcA = 32'd9; bus.srcB = 32'd3;
        @(posedge clk);
        @(negedge clk);
        bus.en = 1'b0; bus.op = 2'b10; bus.srcA = 32'h5A5A5A5A; bus.srcB = 32'h0;
        wait_done(lat, ok);
        check("ign_latency", 64'(lat + 6), 64'd33);
        check("ign_result", {bus.hi, bus.lo}, 64'hFFFFFFFF_FFFFFFF1);

        // Accept during the done cycle.
        start(2'b01, 32'd3, 32'd4);
        check("b2b_busy", {63'd0, bus.busy}, 64'd1);
        wait_done(lat, ok);
        check("b2b_latency", 64'(lat), 64'd33);
        check("b2b_result", {bus.hi, bus.lo}, 64'd12);

        // en held high: one operation per 34 cycles.
        bus.en = 1'b1; bus.op = 2'b01; bus.srcA = 32'd2; bus.srcB = 32'd3;
        @(posedge clk);
        @(negedge clk);
        wait_done(lat, ok);
        check("hold_first", {bus.hi, bus.lo}, 64'd6);
        @(posedge clk);
        @(negedge clk);
        wait_done(lat, ok);
        check("hold_period", 64'(lat + 1), 64'd34);
        bus.en = 1'b0;
        @(posedge clk);
        @(negedge clk);
        @(posedge clk);
        @(negedge clk);
        check("hold_stop", {63'd0, bus.busy}, 64'd0);

        // Reset in the middle of a divide.
        start(2'b11, 32'd100, 32'd7);
        for (int k = 1; k <= 10; k++) begin
            @(posedge clk);
            @(negedge clk);
        end
        rst = 1'b1;
        #1;
        check("rst_busy", {63'd0, bus.busy}, 64'd0);
        check("rst_hilo", {bus.hi, bus.lo}, 64'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        ok = 1'b1;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (bus.done || bus.busy) ok = 1'b0;
        end
        check("rst_no_done", {63'd0, ok}, 64'd1);
        start(2'b00, 32'd6, 32'd7);
        wait_done(lat, ok);
        check("rst_after_latency", 64'(lat), 64'd33);
        check("rst_after_result", {bus.hi, bus.lo}, 64'd42);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/muldiv_unit.md
# muldiv_unit

Iterative multiply/divide responder for the multicycle MIPS datapath. The control unit pulses `en` with an operation and two operands. The block computes MULT/MULTU/DIV/DIVU over 32 iteration cycles and returns the 64-bit result in `hi`/`lo` with a one-cycle `done` pulse. It is the responder side of the en/done handshake the control unit uses for every functional submodule, and it backs the MIPS HI/LO registers for mfhi/mflo.

## Interface
- Parameters: none (width fixed at 32).
- `clk` input 1: single clock; all state changes on the rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `en` input 1: start request; sampled only when idle.
- `op` input 2: operation; 2'b00 MULT, 2'b01 MULTU, 2'b10 DIV, 2'b11 DIVU.
- `srcA` input 32: multiplicand or dividend ($rs).
- `srcB` input 32: multiplier or divisor ($rt).
- `hi` output 32: product[63:32] or remainder.
- `lo` output 32: product[31:0] or quotient.
- `busy` output 1: high while an operation is in flight.
- `done` output 1: one-cycle completion pulse.
- `div_by_zero` output 1: high with `done` when a DIV/DIVU had `srcB == 0`.

## Operation
- States: IDLE, RUN, FIX.
- **IDLE**
  - `en=1` captures `op`, |srcA|, |srcB| (magnitudes for signed ops, raw values for unsigned ops), the result sign flags, and clears the 6-bit iteration counter.
  - Next state is RUN.
  - Exception: DIV/DIVU with `srcB==0` goes straight to FIX with the zero flag set.
- **RUN**: one iteration per cycle; the counter counts 0..31, then the block moves to FIX.
  - Multiply: shift-add over a 64-bit accumulator, using the LSB of the multiplier.
  - Divide: restoring division with a 33-bit partial remainder, shifting in quotient bits MSB first.
- **FIX** (single cycle): sign correction, then write `hi`/`lo`.
  - MULT: negate the 64-bit product when the operand signs differ.
  - DIV: negate the quotient when the signs differ; the remainder takes the sign of the dividend.
  - Divide by zero: `hi=srcA` as captured, `lo=32'hFFFFFFFF`, `div_by_zero=1`.
  - Next state is IDLE.
- Overflow case DIV 0x80000000 / 0xFFFFFFFF gives `lo=32'h80000000`, `hi=0`. No trap and no flag.
- `hi`/`lo` change only at the FIX edge. They hold their values between operations.
- Operands are captured at accept. Changes to `srcA`/`srcB`/`op` while busy are ignored.
- `en` in RUN or FIX is ignored and not queued.

## Timing
- Reset (async, immediate): state IDLE, `hi=0`, `lo=0`, `busy=0`, `done=0`, `div_by_zero=0`, counter 0.
- `busy` is registered:
  - It goes high in the cycle after the accept edge.
  - It goes low in the same cycle that `done` is high.
- Normal latency:
  - Accept at edge E0.
  - Iterations at edges E1..E32.
  - FIX at edge E33.
  - `done=1` for exactly the cycle between E33 and E34, with `hi`/`lo` already valid.
- Divide-by-zero latency: accept at E0, FIX at E1, and `done`/`div_by_zero` high in the cycle after E1.
- `div_by_zero` is 0 whenever `done` is 0.
- Back-to-back: `en=1` during the `done` cycle is accepted, since the state is already IDLE. The next `done` follows 33 cycles later.
- `en` held high continuously produces one operation per 34 cycles. No double accept.
- Reset asserted mid-operation aborts the operation:
  - no `done`;
  - `hi`/`lo` return to 0;
  - the next `en` after reset release is accepted normally.

## Test plan
- MULT `srcA=32'hFFFFFFFD` (-3), `srcB=5` -> `done` 33 cycles after accept, `hi=32'hFFFFFFFF`, `lo=32'hFFFFFFF1`, `busy` high for cycles 1..32.
- MULTU `32'hFFFFFFFF` × `32'hFFFFFFFF` -> `hi=32'hFFFFFFFE`, `lo=32'h00000001`.
- DIV -7/2 -> `lo=32'hFFFFFFFD`, `hi=32'hFFFFFFFF`. DIVU 100/7 -> `lo=14`, `hi=2`. DIV 0x80000000 / -1 -> `lo=32'h80000000`, `hi=0`.
- DIVU `srcA=32'h1234`, `srcB=0` -> `done` and `div_by_zero` high in the cycle after E1, `hi=32'h1234`, `lo=32'hFFFFFFFF`.
- `en` pulsed at cycle 5 of a MULT with different operands, and operands changed while busy -> no effect, result matches the first op. Then `en` during the `done` cycle -> second op accepted, `done` again 33 cycles later.
- `rst` asserted at iteration 10 of a DIV -> `busy`/`hi`/`lo` go to 0 immediately, no `done`. A new MULT 6×7 after release gives `lo=42`, `hi=0`.
